// File: rtl/system_pio_keys.sv
// Debounced key/switch PIO with edge capture, interrupt mask and Avalon-MM register access.
// Latency: in_port -> debounced data 2 + DB_COUNT cycles; edge_capture one cycle later; reads combinational.
// Backpressure: none; zero-wait-state slave, every access completes in the cycle it is presented.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   address, chipselect,  - Avalon-MM slave: 0 data (RO), 1 raw sync (RO),
//   write_n, writedata,     2 irq_mask (RW), 3 edge_capture (write-1-to-clear)
//   readdata
//   in_port               - asynchronous key/switch inputs, one bit per key
//   irq                   - level interrupt, OR of masked captured edges
module system_pio_keys #(
  parameter int WIDTH          = 4,
  parameter int DB_COUNT       = 50000,
  parameter int CAPTURE_RISING = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DB_COUNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);
  // Released-key level: reset state for the whole input path, so leaving
  // reset never looks like a key press.
  localparam logic [WIDTH-1:0] IDLE = (CAPTURE_RISING != 0) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] dly_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  logic             wr_en;
  logic [WIDTH-1:0] new_edge;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  // Debounce: a bit's counter runs only while the synchronized input
  // disagrees with the accepted level; any agreement restarts it.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign new_edge = (CAPTURE_RISING != 0) ? (db_q & ~dly_q) : (dly_q & ~db_q);

  // Clear is applied first so that an edge arriving in the same cycle wins.
  always_comb begin
    edge_d = edge_q;
    if (wr_en && address == 2'd3) begin
      edge_d = edge_q & ~writedata[WIDTH-1:0];
    end
    edge_d = edge_d | new_edge;
  end

  always_comb begin
    mask_d = mask_q;
    if (wr_en && address == 2'd2) begin
      mask_d = writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= IDLE;
      sync_q <= IDLE;
      db_q   <= IDLE;
      dly_q  <= IDLE;
      mask_q <= '0;
      edge_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      meta_q <= in_port;
      sync_q <= meta_q;
      db_q   <= db_d;
      dly_q  <= db_q;
      mask_q <= mask_d;
      edge_q <= edge_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = db_q;
      2'd1:    readdata[WIDTH-1:0] = sync_q;
      2'd2:    readdata[WIDTH-1:0] = mask_q;
      default: readdata[WIDTH-1:0] = edge_q;
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: doc/system_pio_keys.md
SYSTEM_PIO_KEYS -- requirements
Module: system_pio_keys

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of input bits (1..32).
REQ-002 SHALL have parameter DB_COUNT, default 50000, number of consecutive stable cycles needed to accept a new input level (>=2).
REQ-003 SHALL have parameter CAPTURE_RISING, default 0: 0 = capture falling edges (active-low keys), 1 = capture rising edges.
REQ-004 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 address  input  2  Avalon-MM slave register select.
REQ-007 chipselect  input  1  slave access qualifier.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous external key/switch inputs.
REQ-011 readdata  output  32  read data, combinational from address, zero-extended above WIDTH.
REQ-012 irq  output  1  active-high level interrupt request.

Function
REQ-013 Register map SHALL be: 0 = debounced data (RO), 1 = raw synchronized input (RO), 2 = irq_mask (RW, WIDTH bits), 3 = edge_capture (RW1C).
REQ-014 Reads SHALL be zero-wait-state, combinational on address; bits [31:WIDTH] SHALL read 0; reads have no side effects.
REQ-015 Writes SHALL take effect when chipselect=1 and write_n=0 at a rising clk edge; writes to addresses 0 and 1 SHALL be ignored.
REQ-016 in_port SHALL pass through a two-flop synchronizer per bit; sync output lags in_port by 2 cycles.
REQ-017 Each bit SHALL own a debounce counter of width ceil(log2(DB_COUNT)) bits.
REQ-018 Counter per bit: cleared when sync bit equals debounced bit; otherwise incremented each cycle.
REQ-019 When counter equals DB_COUNT-1 and the bit still differs, the debounced bit SHALL take the sync value and the counter SHALL clear in the same cycle.
REQ-020 Any glitch shorter than DB_COUNT cycles (sync bit returning to debounced value) SHALL clear the counter and SHALL NOT change debounced data.
REQ-021 Latency from a stable in_port change to debounced data update SHALL be exactly 2 + DB_COUNT cycles.
REQ-022 Edge detect SHALL compare debounced data with a one-cycle delayed copy; a capturing transition (per CAPTURE_RISING) SHALL set the edge_capture bit one cycle after debounced data changes.
REQ-023 Writing 1 to an edge_capture bit SHALL clear it; writing 0 SHALL leave it unchanged.
REQ-024 Simultaneous set (new edge) and write-1-clear on the same bit in the same cycle: set SHALL win, bit stays 1.
REQ-025 A set edge_capture bit SHALL remain set on further edges until cleared (sticky, no counting).
REQ-026 irq SHALL equal OR over (edge_capture & irq_mask), driven combinationally from registers, with no extra latency.
REQ-027 Changing irq_mask SHALL NOT alter edge_capture; unmasking a pending bit SHALL assert irq the cycle after the write.

Reset
REQ-028 While reset=1 at a clk edge: synchronizer flops, delayed copy and debounced data SHALL load all-ones if CAPTURE_RISING=0, all-zeros if 1 (released-key level), so no spurious edge is captured after reset.
REQ-029 Reset SHALL clear all debounce counters, irq_mask and edge_capture; irq SHALL be 0 and readdata for addresses 0/2/3 SHALL reflect these values in the cycle after reset.
REQ-030 Reset asserted mid-debounce or with pending edges SHALL discard all progress; no edge SHALL be captured for a transition in progress at reset.

Verification (WIDTH=4, DB_COUNT=4, CAPTURE_RISING=0)
REQ-031 Reset, in_port=4'hF -> addr0 reads 0xF, addr2 0x0, addr3 0x0, irq=0; no edge captured over 20 cycles.
REQ-032 in_port bit0 driven 0 and held -> addr0 reads 0xE exactly 6 cycles later, addr3 reads 0x1 one cycle after; irq stays 0 (mask 0).
REQ-033 bit1 pulsed low for 3 cycles then high -> addr0 stays 0xF, addr1 shows the pulse delayed 2 cycles, addr3 stays 0x0.
REQ-034 Write addr2=0x1 with addr3=0x1 pending -> irq=1 the cycle after the write; write addr3=0x1 -> addr3=0x0, irq=0 next cycle.
REQ-035 New falling edge on bit0 landing in the same cycle as a write addr3=0x1 -> addr3 bit0 remains 1, irq stays 1.
REQ-036 Assert reset 2 cycles into a bit2 debounce -> after release addr0=0xF (in_port still 0xB) until 6 cycles of stable low elapse, then 0xB and addr3=0x4.
